// File: rtl/iz_param_loader.sv
// Byte-serial parameter loader for the Izhikevich neuron core: framed a/b/c/d packets, XOR checksum, atomic commit.
// Define IZ_LOADER_DEFAULTS_EN to reset param_* to the *_DEFAULT values with a valid parameter set present.
module iz_param_loader #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [15:0] A_DEFAULT      = 16'h0002,
    parameter logic [15:0] B_DEFAULT      = 16'h000D,
    parameter logic [15:0] C_DEFAULT      = 16'hEFC0,
    parameter logic [15:0] D_DEFAULT      = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        err_clear,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        load_done,
    output logic        load_error,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready; byte_in is
    // only sampled then, and byte_ready never depends on byte_valid.

`ifdef IZ_LOADER_DEFAULTS_EN
    localparam logic DEF_EN = 1'b1;
`else
    localparam logic DEF_EN = 1'b0;
`endif

    localparam logic [15:0] A_RST = DEF_EN ? A_DEFAULT : 16'h0000;
    localparam logic [15:0] B_RST = DEF_EN ? B_DEFAULT : 16'h0000;
    localparam logic [15:0] C_RST = DEF_EN ? C_DEFAULT : 16'h0000;
    localparam logic [15:0] D_RST = DEF_EN ? D_DEFAULT : 16'h0000;

    localparam int             IW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CSUM   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [2:0]    cnt;
    logic [7:0]    csum_acc;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    shadow [8];
    logic          has_params, has_params_n;
    logic          xfer, idle_hit, timeout, csum_bad;

    assign xfer         = byte_valid && byte_ready;
    assign idle_hit     = (idle_cnt == IDLE_LAST);
    assign byte_ready   = (state != S_COMMIT);
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;
    assign has_params_n = has_params | (state == S_COMMIT);

    always_comb begin
        state_n  = state;
        timeout  = 1'b0;
        csum_bad = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer && byte_in == HEADER) state_n = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    if (cnt == 3'd7) state_n = S_CSUM;
                end else if (idle_hit) begin
                    state_n = S_IDLE;
                    timeout = 1'b1;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (byte_in == csum_acc) begin
                        state_n = S_COMMIT;
                    end else begin
                        state_n  = S_IDLE;
                        csum_bad = 1'b1;
                    end
                end else if (idle_hit) begin
                    state_n = S_IDLE;
                    timeout = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            csum_acc     <= '0;
            idle_cnt     <= '0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
            param_a      <= A_RST;
            param_b      <= B_RST;
            param_c      <= C_RST;
            param_d      <= D_RST;
            has_params   <= DEF_EN;
            params_ready <= DEF_EN;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    csum_acc <= '0;
                    idle_cnt <= '0;
                end
                S_DATA, S_CSUM: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (state == S_DATA) begin
                            shadow[cnt] <= byte_in;
                            csum_acc    <= csum_acc ^ byte_in;
                            cnt         <= cnt + 3'd1;
                        end
                    end else if (timeout) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: begin
                    param_a <= {shadow[0], shadow[1]};
                    param_b <= {shadow[2], shadow[3]};
                    param_c <= {shadow[4], shadow[5]};
                    param_d <= {shadow[6], shadow[7]};
                end
            endcase
            has_params   <= has_params_n;
            // Registered from next-state so it drops with HEADER and rises with the new params.
            params_ready <= has_params_n && (state_n == S_IDLE);
            load_done    <= (state == S_COMMIT);
            load_error   <= (timeout || csum_bad) || (load_error && !err_clear);
        end
    end

endmodule
